// File: rtl/tvip_clock_divider.sv
// Multi-channel programmable divided-clock generator: each channel produces a 50%-duty clock,
// its complement and a rising-edge strobe from clk, with glitch-free start/stop.
module tvip_clock_divider #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned COUNTER_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS-1:0]               i_start,
    input  logic [CHANNELS-1:0]               i_stop,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] i_half_period,
    output logic [CHANNELS-1:0]               o_clk_p,
    output logic [CHANNELS-1:0]               o_clk_n,
    output logic [CHANNELS-1:0]               o_rise,
    output logic [CHANNELS-1:0]               o_busy,
    output logic [CHANNELS-1:0]               o_start_error
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRunning  = 2'd1,
        StStopping = 2'd2
    } state_e;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        state_e                   state_q, state_d;
        logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
        logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
        logic [COUNTER_WIDTH-1:0] hp;
        logic                     clk_p_q, clk_p_d;
        logic                     clk_n_q, clk_n_d;
        logic                     rise_q, rise_d;
        logic                     err_q, err_d;
        logic                     busy_q, busy_d;
        logic                     start_req;
        logic                     stop_path;
        logic                     cnt_zero;

        assign hp        = i_half_period[g*COUNTER_WIDTH +: COUNTER_WIDTH];
        assign start_req = i_start[g] & ~i_stop[g];
        assign cnt_zero  = (cnt_q == '0);
        // Heading for IDLE at the end of this high phase: a fresh stop while running, or
        // an existing stop that has not been cancelled by a clean start.
        assign stop_path = (state_q == StRunning) ? i_stop[g] : ~start_req;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            shadow_d = shadow_q;
            clk_p_d  = clk_p_q;
            rise_d   = 1'b0;
            err_d    = 1'b0;

            case (state_q)
                StIdle: begin
                    clk_p_d = 1'b0;
                    if (start_req) begin
                        if (hp != '0) begin
                            state_d  = StRunning;
                            shadow_d = hp;
                            cnt_d    = hp - 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                StRunning, StStopping: begin
                    if ((state_q == StRunning) && i_stop[g] && !clk_p_q) begin
                        // Low phase: parking now cannot shorten a pulse.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (!cnt_zero) begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = stop_path ? StStopping : StRunning;
                    end else if (stop_path) begin
                        clk_p_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        clk_p_d = ~clk_p_q;
                        rise_d  = ~clk_p_q;
                        state_d = StRunning;
                        if (hp != '0) begin
                            shadow_d = hp;
                            cnt_d    = hp - 1'b1;
                        end else begin
                            err_d = 1'b1;
                            cnt_d = shadow_q - 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    clk_p_d = 1'b0;
                end
            endcase

            busy_d  = (state_d != StIdle);
            clk_n_d = busy_d & ~clk_p_d;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                shadow_q <= '0;
                clk_p_q  <= 1'b0;
                clk_n_q  <= 1'b0;
                rise_q   <= 1'b0;
                err_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                shadow_q <= shadow_d;
                clk_p_q  <= clk_p_d;
                clk_n_q  <= clk_n_d;
                rise_q   <= rise_d;
                err_q    <= err_d;
                busy_q   <= busy_d;
            end
        end

        assign o_clk_p[g]       = clk_p_q;
        assign o_clk_n[g]       = clk_n_q;
        assign o_rise[g]        = rise_q;
        assign o_busy[g]        = busy_q;
        assign o_start_error[g] = err_q;
    end

endmodule

// File: tb/tb_tvip_clock_divider.sv
// Randomized and directed bench for tvip_clock_divider: a phase-level reference model predicts
// every cycle's outputs into a queue that an independent monitor drains and compares.
module tb_tvip_clock_divider;

    localparam int CH = 2;
    localparam int W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     i_start = '0;
    logic [CH-1:0]     i_stop = '0;
    logic [CH*W-1:0]   i_half_period = '0;
    logic [CH-1:0]     o_clk_p, o_clk_n, o_rise, o_busy, o_start_error;

    tvip_clock_divider #(
        .CHANNELS      (CH),
        .COUNTER_WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_half_period (i_half_period),
        .o_clk_p       (o_clk_p),
        .o_clk_n       (o_clk_n),
        .o_rise        (o_rise),
        .o_busy        (o_busy),
        .o_start_error (o_start_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] p;
        logic [CH-1:0] n;
        logic [CH-1:0] r;
        logic [CH-1:0] b;
        logic [CH-1:0] e;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus intent, applied once per cycle by step().
    bit            rst_b = 1'b1;
    bit [CH-1:0]   st = '0;
    bit [CH-1:0]   sp = '0;
    int            hp[CH];

    // Reference model: a channel is either idle or in a half phase with some cycles left.
    bit m_active[CH], m_stopping[CH], m_level[CH], m_rise[CH], m_err[CH];
    int m_remain[CH], m_shadow[CH];

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            m_rise[c] = 1'b0;
            m_err[c]  = 1'b0;
            if (rst_b) begin
                m_active[c] = 0; m_stopping[c] = 0; m_level[c] = 0;
                m_remain[c] = 0; m_shadow[c] = 0;
            end else if (!m_active[c]) begin
                if (st[c] && !sp[c]) begin
                    if (hp[c] != 0) begin
                        m_active[c] = 1; m_level[c] = 0;
                        m_remain[c] = hp[c]; m_shadow[c] = hp[c];
                    end else begin
                        m_err[c] = 1;
                    end
                end
            end else if (!m_stopping[c] && sp[c] && !m_level[c]) begin
                m_active[c] = 0;
            end else begin
                if (!m_stopping[c] && sp[c]) m_stopping[c] = 1;
                else if (m_stopping[c] && st[c] && !sp[c]) m_stopping[c] = 0;
                m_remain[c]--;
                if (m_remain[c] == 0) begin
                    if (m_stopping[c]) begin
                        m_active[c] = 0; m_stopping[c] = 0; m_level[c] = 0;
                    end else begin
                        m_level[c] = !m_level[c];
                        m_rise[c]  = m_level[c];
                        if (hp[c] == 0) begin
                            m_err[c]    = 1;
                            m_remain[c] = m_shadow[c];
                        end else begin
                            m_shadow[c] = hp[c];
                            m_remain[c] = hp[c];
                        end
                    end
                end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        for (int c = 0; c < CH; c++) begin
            o.p[c] = m_active[c] && m_level[c];
            o.n[c] = m_active[c] && !m_level[c];
            o.r[c] = m_rise[c];
            o.b[c] = m_active[c];
            o.e[c] = m_err[c];
        end
        return o;
    endfunction

    task automatic step();
        obs_t act;
        @(posedge clk);
        #2;
        rst     = rst_b;
        i_start = st;
        i_stop  = sp;
        for (int c = 0; c < CH; c++) i_half_period[c*W +: W] = hp[c][W-1:0];
        if (rst_b) begin
            #1;
            act = {o_clk_p, o_clk_n, o_rise, o_busy, o_start_error};
            total++;
            if (act !== '0) begin
                bad++;
                $display("FAIL async_reset t=%0t got=%h want=0", $time, act);
            end
        end
        model_step();
        exp_q.push_back(model_obs());
    endtask

    // Advance until channel c is c_elapsed cycles into a half phase at level lvl.
    task automatic wait_phase(input int c, input bit lvl, input int c_elapsed);
        int n = 0;
        while (!(m_active[c] && !m_stopping[c] && m_level[c] == lvl && m_shadow[c] == hp[c] &&
                 (m_shadow[c] - m_remain[c]) == c_elapsed) && n < 600) begin
            step();
            n++;
        end
        total++;
        if (n >= 600) begin
            bad++;
            $display("FAIL wait_phase ch=%0d got=timeout want=level %0b elapsed %0d",
                     c, lvl, c_elapsed);
        end
    endtask

    // Monitor: outputs settle by 1 time unit after each edge; stimulus moves at 2.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {o_clk_p, o_clk_n, o_rise, o_busy, o_start_error};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got p=%b n=%b r=%b b=%b e=%b want p=%b n=%b r=%b b=%b e=%b",
                             $time, a.p, a.n, a.r, a.b, a.e, e.p, e.n, e.r, e.b, e.e);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < CH; c++) hp[c] = 0;
        repeat (2) step();
        rst_b = 0;
        repeat (3) step();

        // Basic divide, ch0 HP=4.
        hp[0] = 4; st[0] = 1; step(); st[0] = 0;
        repeat (40) step();

        // Period change on ch1 during its high phase.
        hp[1] = 2; st[1] = 1; step(); st[1] = 0;
        wait_phase(1, 1, 1);
        hp[1] = 5;
        repeat (30) step();

        // Glitch-free stop two cycles into the high phase, then stop during low phase.
        hp[0] = 6;
        wait_phase(0, 1, 2);
        sp[0] = 1; step(); sp[0] = 0;
        repeat (12) step();
        st[0] = 1; step(); st[0] = 0;
        wait_phase(0, 0, 2);
        sp[0] = 1; step(); sp[0] = 0;
        repeat (4) step();

        // Rejected start, then start+stop together in idle.
        hp[0] = 0; st[0] = 1; step(); st[0] = 0;
        repeat (3) step();
        hp[0] = 3; st[0] = 1; sp[0] = 1; step(); st[0] = 0; sp[0] = 0;
        repeat (3) step();

        // Start while stopping cancels the stop.
        hp[0] = 6; st[0] = 1; step(); st[0] = 0;
        wait_phase(0, 1, 1);
        sp[0] = 1; step(); sp[0] = 0;
        step();
        st[0] = 1; step(); st[0] = 0;
        repeat (20) step();

        // Reset mid-run.
        hp[0] = 3;
        repeat (10) step();
        rst_b = 1; step(); step();
        rst_b = 0;
        repeat (5) step();

        // Extremes: clk/2 on ch0 alongside the longest period on ch1.
        hp[0] = 1; hp[1] = 255; st = 2'b11; step(); st = '0;
        repeat (1100) step();
        sp[1] = 1;
        repeat (300) step();
        sp[1] = 0;
        repeat (20) step();
        sp[0] = 1; repeat (2) step(); sp[0] = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_b = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < CH; c++) begin
                int r;
                st[c] = ($urandom_range(0, 9) == 0);
                sp[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    r = $urandom_range(0, 7);
                    hp[c] = (r <= 4) ? r : $urandom_range(1, 12);
                end
            end
            step();
        end
        rst_b = 0; st = '0; sp = '0;
        repeat (3) step();

        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
